// File: rtl/arm_mem_pkg.sv
// Shared types and widths for the MEM-stage SRAM bridge.
package arm_mem_pkg;
  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_DONE   = 2'd2
  } mem_state_e;

  localparam int          SRAM_ADDR_W     = 17;
  localparam int          SRAM_DATA_W     = 64;
  localparam int          WORD_W          = 32;
  localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
  localparam int          DEF_WAIT_CYCLES = 5;
endpackage

// File: rtl/sram_mem_controller_if.sv
// MEM-stage request/response bundle; master is the pipeline, slave the controller.
interface sram_mem_controller_if;
  import arm_mem_pkg::*;
  logic              rd_en;
  logic              wr_en;
  logic [31:0]       addr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic              ready;
  logic              freeze;

  modport master (output rd_en, wr_en, addr, wdata, input rdata, ready, freeze);
  modport slave  (input rd_en, wr_en, addr, wdata, output rdata, ready, freeze);
endinterface

// File: rtl/sram_mem_controller.sv
// Fixed-wait SRAM bridge for the MEM stage; freezes the pipeline during an access.
// Optional last-read hit register enabled by defining SRAM_READ_HIT_EN.
module sram_mem_controller
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_mem_controller_if.slave   bus,
  output logic                   SRAM_WE_N,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ
);
  mem_state_e             state, state_nxt;
  logic [3:0]             cnt;
  logic [WORD_W-1:0]      wdata_q, rdata_q, dq_in;
  logic                   wr_q;
  logic [SRAM_ADDR_W-1:0] word_addr;
  logic                   req, hit, acc_last, accept;
  logic                   dq_oe, ready_c, freeze_c, we_n_c;

  // 32-bit wrapping subtract, then drop to the 17-bit word index
  assign word_addr = SRAM_ADDR_W'((bus.addr - BASE_ADDR) >> 2);
  assign req       = bus.rd_en | bus.wr_en;
  assign acc_last  = (state == MEM_ACCESS) && (cnt == 4'd0);
  assign accept    = (state == MEM_IDLE) && req && !hit;
  assign dq_in     = WORD_W'(SRAM_DQ);

`ifdef SRAM_READ_HIT_EN
  logic                   hit_vld;
  logic [SRAM_ADDR_W-1:0] hit_addr;
  logic [WORD_W-1:0]      hit_data;

  assign hit = bus.rd_en && !bus.wr_en && hit_vld && (hit_addr == word_addr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_vld  <= 1'b0;
      hit_addr <= '0;
      hit_data <= '0;
    end else if (state == MEM_IDLE && bus.wr_en) begin
      hit_vld <= 1'b0;
    end else if (acc_last && !wr_q) begin
      hit_vld  <= 1'b1;
      hit_addr <= SRAM_ADDR;
      hit_data <= dq_in;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    dq_oe     = 1'b0;
    we_n_c    = 1'b1;
    ready_c   = 1'b0;
    freeze_c  = rst && req && (state != MEM_DONE);
    case (state)
      MEM_IDLE:   if (req) state_nxt = hit ? MEM_DONE : MEM_ACCESS;
      MEM_ACCESS: begin
        dq_oe  = wr_q;
        we_n_c = !wr_q;
        if (cnt == 4'd0) state_nxt = MEM_DONE;
      end
      MEM_DONE:   begin
        ready_c   = 1'b1;
        state_nxt = MEM_IDLE;
      end
      default:    state_nxt = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= MEM_IDLE;
      cnt       <= 4'd0;
      SRAM_ADDR <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        SRAM_ADDR <= word_addr;
        wdata_q   <= bus.wdata;
        wr_q      <= bus.wr_en;
        cnt       <= 4'(WAIT_CYCLES - 1);
      end else if (state == MEM_ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (acc_last && !wr_q) rdata_q <= dq_in;
`ifdef SRAM_READ_HIT_EN
      else if (state == MEM_IDLE && hit) rdata_q <= hit_data;
`endif
    end
  end

  assign SRAM_WE_N  = we_n_c;
  assign SRAM_DQ    = dq_oe ? {{(SRAM_DATA_W-WORD_W){1'b0}}, wdata_q} : {SRAM_DATA_W{1'bz}};
  assign bus.rdata  = rdata_q;
  assign bus.ready  = ready_c;
  assign bus.freeze = freeze_c;
endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller with a small SRAM model on the DQ bus.
module tb_sram_mem_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic        sram_we_n;
  logic [16:0] sram_addr;
  wire  [63:0] sram_dq;
  logic        tb_oe;
  logic [31:0] mem [0:15];
  int          checks = 0;
  int          failures = 0;

  sram_mem_controller_if bus();

  sram_mem_controller dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .SRAM_WE_N (sram_we_n),
    .SRAM_ADDR (sram_addr),
    .SRAM_DQ   (sram_dq)
  );

  always #5 clk = ~clk;

  // SRAM model: upper lanes carry junk on reads so ignoring them is exercised
  assign sram_dq = (tb_oe && sram_we_n) ? {32'hFFFF_FFFF, mem[sram_addr[3:0]]} : {64{1'bz}};
  always @(posedge clk) if (!sram_we_n) mem[sram_addr[3:0]] <= sram_dq[31:0];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[3] = 32'hCAFE_F00D;
    tb_oe = 1'b0;
    rst = 1'b0;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
    tick(); tick();
    check("rst_we_n",   64'(sram_we_n), 64'd1);
    check("rst_oe",     64'(dut.dq_oe), 64'd0);
    check("rst_freeze", 64'(bus.freeze), 64'd0);
    check("rst_ready",  64'(bus.ready), 64'd0);
    check("rst_rdata",  64'(bus.rdata), 64'd0);
    check("rst_addr",   64'(sram_addr), 64'd0);
    rst = 1'b1;
    tick();

    // store 0xDEADBEEF to 0x408 -> word 2
    bus.wr_en = 1'b1; bus.addr = 32'h408; bus.wdata = 32'hDEAD_BEEF;
    #1 check("st_freeze0", 64'(bus.freeze), 64'd1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      check("st_we_n",   64'(sram_we_n), 64'd0);
      check("st_addr",   64'(sram_addr), 64'd2);
      check("st_dq",     sram_dq, 64'h0000_0000_DEAD_BEEF);
      check("st_freeze", 64'(bus.freeze), 64'd1);
      check("st_ready",  64'(bus.ready), 64'd0);
    end
    tick();
    check("st_ready6",  64'(bus.ready), 64'd1);
    check("st_freeze6", 64'(bus.freeze), 64'd0);
    check("st_we_n6",   64'(sram_we_n), 64'd1);
    bus.wr_en = 1'b0;
    tick();
    check("st_ready7", 64'(bus.ready), 64'd0);

    // load back from 0x408
    tb_oe = 1'b1;
    bus.rd_en = 1'b1; bus.addr = 32'h408;
    #1 check("ld_freeze0", 64'(bus.freeze), 64'd1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      check("ld_we_n",   64'(sram_we_n), 64'd1);
      check("ld_freeze", 64'(bus.freeze), 64'd1);
      check("ld_ready",  64'(bus.ready), 64'd0);
    end
    tick();
    check("ld_ready6", 64'(bus.ready), 64'd1);
    check("ld_rdata",  64'(bus.rdata), 64'hDEAD_BEEF);
    bus.rd_en = 1'b0;
    tick();

    // repeat load of the same word
    bus.rd_en = 1'b1; bus.addr = 32'h408;
    tick();
`ifdef SRAM_READ_HIT_EN
    check("hit_ready1",  64'(bus.ready), 64'd1);
    check("hit_freeze1", 64'(bus.freeze), 64'd0);
    check("hit_rdata",   64'(bus.rdata), 64'hDEAD_BEEF);
    check("hit_oe",      64'(dut.dq_oe), 64'd0);
`else
    check("rl_ready1",  64'(bus.ready), 64'd0);
    check("rl_freeze1", 64'(bus.freeze), 64'd1);
    repeat (5) tick();
    check("rl_ready6",  64'(bus.ready), 64'd1);
    check("rl_rdata",   64'(bus.rdata), 64'hDEAD_BEEF);
`endif
    bus.rd_en = 1'b0;
    tick();

    // rd_en and wr_en together: treated as a write to word 4
    bus.rd_en = 1'b1; bus.wr_en = 1'b1; bus.addr = 32'h410; bus.wdata = 32'h1111_2222;
    tick();
    check("sim_we_n", 64'(sram_we_n), 64'd0);
    check("sim_dq",   sram_dq, 64'h0000_0000_1111_2222);
    repeat (4) tick();
    tick();
    check("sim_ready", 64'(bus.ready), 64'd1);
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    tick();
    // back-to-back load of 0x40C in the cycle after DONE
    bus.rd_en = 1'b1; bus.addr = 32'h40C;
    #1 check("b2b_freeze0", 64'(bus.freeze), 64'd1);
    tick();
    check("b2b_acc", 64'(sram_addr), 64'd3);
    repeat (4) tick();
    tick();
    check("b2b_ready", 64'(bus.ready), 64'd1);
    check("b2b_rdata", 64'(bus.rdata), 64'hCAFE_F00D);
    bus.rd_en = 1'b0;
    tick();

    // load word 4 to confirm the simultaneous request wrote
    bus.rd_en = 1'b1; bus.addr = 32'h410;
    repeat (6) tick();
    check("sim_rd_ready", 64'(bus.ready), 64'd1);
    check("sim_rd_rdata", 64'(bus.rdata), 64'h1111_2222);
    bus.rd_en = 1'b0;
    tick();

    // address below BASE_ADDR wraps: (0 - 1024) >> 2 truncated
    bus.rd_en = 1'b1; bus.addr = 32'h0;
    tick();
    check("wrap_addr", 64'(sram_addr), 64'h1FF00);
    repeat (5) tick();
    check("wrap_ready", 64'(bus.ready), 64'd1);
    bus.rd_en = 1'b0;
    tick();

    // load 0x408, store new data there, load again: full latency and fresh data
    bus.rd_en = 1'b1; bus.addr = 32'h408;
    repeat (6) tick();
    bus.rd_en = 1'b0;
    tick();
    bus.wr_en = 1'b1; bus.wdata = 32'hAAAA_5555;
    repeat (6) tick();
    check("inv_st_ready", 64'(bus.ready), 64'd1);
    bus.wr_en = 1'b0;
    tick();
    bus.rd_en = 1'b1;
    tick();
    check("inv_ready1", 64'(bus.ready), 64'd0);
    repeat (5) tick();
    check("inv_ready6", 64'(bus.ready), 64'd1);
    check("inv_rdata",  64'(bus.rdata), 64'hAAAA_5555);
    bus.rd_en = 1'b0;
    tick();

    // reset asserted at ACCESS cycle 3 of a write
    bus.wr_en = 1'b1; bus.addr = 32'h414; bus.wdata = 32'h5555_5555;
    repeat (3) tick();
    check("mr_we_n3", 64'(sram_we_n), 64'd0);
    rst = 1'b0;
    #1 check("mr_freeze_rst", 64'(bus.freeze), 64'd0);
    tick();
    check("mr_we_n",  64'(sram_we_n), 64'd1);
    check("mr_oe",    64'(dut.dq_oe), 64'd0);
    check("mr_ready", 64'(bus.ready), 64'd0);
    check("mr_addr",  64'(sram_addr), 64'd0);
    check("mr_rdata", 64'(bus.rdata), 64'd0);
    rst = 1'b1; bus.wr_en = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("mr_no_ready", 64'(bus.ready), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
